// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared branch-type codes, ALUFun[3:1] compare codes and controller state encodings
// used by the branch resolution controller and the ALU compare unit.
package branch_resolve_ctrl_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5
  } br_type_e;

  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_NEQ = 3'b000;
  localparam logic [2:0] CMP_LT  = 3'b010;
  localparam logic [2:0] CMP_LEZ = 3'b110;
  localparam logic [2:0] CMP_LTZ = 3'b101;
  localparam logic [2:0] CMP_GTZ = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_OPND = 2'd1,
    ST_CMP       = 2'd2,
    ST_REDIRECT  = 2'd3
  } br_state_e;

endpackage

// File: rtl/branch_resolve_ctrl_fun_decode.sv
// Combinational decode of a branch type into the compare-unit function code,
// a result-invert flag and a legality flag.
module br_fun_decode
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [2:0] br_type,
  output logic [2:0] cmp_fun,
  output logic       invert,
  output logic       legal
);

  // BGEZ reuses the less-than-zero compare and flips the result
  always_comb begin
    cmp_fun = CMP_NEQ;
    invert  = 1'b0;
    legal   = 1'b1;
    case (br_type)
      BR_BEQ:  cmp_fun = CMP_EQ;
      BR_BNE:  cmp_fun = CMP_NEQ;
      BR_BLEZ: cmp_fun = CMP_LEZ;
      BR_BGTZ: cmp_fun = CMP_GTZ;
      BR_BLTZ: cmp_fun = CMP_LTZ;
      BR_BGEZ: begin
        cmp_fun = CMP_LTZ;
        invert  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Conditional-branch resolution controller: waits for operands, borrows the ALU
// compare path, and issues PC redirect plus IF/ID flush. Define BR_STATS_EN for counters.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            br_valid,
  input  logic [2:0]      br_type,
  input  logic [PC_W-1:0] br_target,
  input  logic            opnd_ready,
  input  logic            ex_alu_busy,
  output logic            cmp_grant,
  output logic [2:0]      cmp_fun,
  input  logic            cmp_result,
  output logic            stall_id,
  output logic            pc_redirect,
  output logic [PC_W-1:0] pc_target,
  output logic            flush_if,
  output logic            br_done
`ifdef BR_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
  output logic [15:0]     stat_alu_conflicts
`endif
);

  localparam logic [2:0] LAST_CNT = 3'(FLUSH_CYCLES - 1);

  br_state_e       state_q, state_d;
  logic [2:0]      type_q, type_d;
  logic [PC_W-1:0] target_q, target_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      dec_fun;
  logic            dec_invert, dec_legal;
  logic            granted, taken;

  br_fun_decode u_fun_decode (
    .br_type (type_q),
    .cmp_fun (dec_fun),
    .invert  (dec_invert),
    .legal   (dec_legal)
  );

  assign granted = (state_q == ST_CMP) && !ex_alu_busy;
  assign taken   = dec_legal && (cmp_result ^ dec_invert);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      type_q   <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          type_d   = br_type;
          target_d = br_target;
          state_d  = opnd_ready ? ST_CMP : ST_WAIT_OPND;
        end
      end
      ST_WAIT_OPND: if (opnd_ready) state_d = ST_CMP;
      ST_CMP: begin
        cnt_d = '0;
        if (granted) state_d = taken ? ST_REDIRECT : ST_IDLE;
      end
      ST_REDIRECT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // pc_target simply exposes the latched target; it only matters while pc_redirect is high
  always_comb begin
    cmp_grant   = 1'b0;
    cmp_fun     = 3'b000;
    stall_id    = 1'b0;
    pc_redirect = 1'b0;
    flush_if    = 1'b0;
    br_done     = 1'b0;
    pc_target   = target_q;
    case (state_q)
      ST_IDLE:      stall_id = br_valid;
      ST_WAIT_OPND: stall_id = 1'b1;
      ST_CMP: begin
        stall_id  = 1'b1;
        cmp_grant = !ex_alu_busy;
        cmp_fun   = dec_fun;
        br_done   = granted && !taken;
      end
      ST_REDIRECT: begin
        pc_redirect = (cnt_q == 3'd0);
        flush_if    = 1'b1;
        br_done     = (cnt_q == LAST_CNT);
      end
      default: ;
    endcase
  end

`ifdef BR_STATS_EN
  logic [31:0] branches_q, branches_d, taken_q, taken_d;
  logic [15:0] conflicts_q, conflicts_d;

  always_comb begin
    branches_d  = branches_q + (br_done ? 32'd1 : 32'd0);
    taken_d     = taken_q + ((br_done && state_q == ST_REDIRECT) ? 32'd1 : 32'd0);
    conflicts_d = conflicts_q;
    if (state_q == ST_CMP && ex_alu_busy && conflicts_q != 16'hFFFF)
      conflicts_d = conflicts_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branches_q  <= '0;
      taken_q     <= '0;
      conflicts_q <= '0;
    end else begin
      branches_q  <= branches_d;
      taken_q     <= taken_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign stat_branches      = branches_q;
  assign stat_taken         = taken_q;
  assign stat_alu_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: a FLUSH_CYCLES=1 instance for most vectors and a
// FLUSH_CYCLES=3 instance for the multi-cycle flush vector. Counter checks under BR_STATS_EN.
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        br_valid = 1'b0;
  logic        sel3 = 1'b0;
  logic [2:0]  br_type = 3'd0;
  logic [31:0] br_target = 32'd0;
  logic        opnd_ready = 1'b0;
  logic        ex_alu_busy = 1'b0;
  logic        cmp_result = 1'b0;

  logic        cmp_grant, stall_id, pc_redirect, flush_if, br_done;
  logic [2:0]  cmp_fun;
  logic [31:0] pc_target;
  logic        cmp_grant_3, stall_id_3, pc_redirect_3, flush_if_3, br_done_3;
  logic [2:0]  cmp_fun_3;
  logic [31:0] pc_target_3;
  logic        br_valid_a, br_valid_b;
`ifdef BR_STATS_EN
  logic [31:0] stat_branches, stat_taken, stat_branches_3, stat_taken_3;
  logic [15:0] stat_alu_conflicts, stat_alu_conflicts_3;
`endif

  int checks = 0;
  int passed = 0;

  assign br_valid_a = br_valid && !sel3;
  assign br_valid_b = br_valid && sel3;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.PC_W(32), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid_a), .br_type(br_type), .br_target(br_target),
    .opnd_ready(opnd_ready), .ex_alu_busy(ex_alu_busy), .cmp_grant(cmp_grant), .cmp_fun(cmp_fun),
    .cmp_result(cmp_result), .stall_id(stall_id), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .flush_if(flush_if), .br_done(br_done)
`ifdef BR_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_alu_conflicts(stat_alu_conflicts)
`endif
  );

  branch_resolve_ctrl #(.PC_W(32), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .br_valid(br_valid_b), .br_type(br_type), .br_target(br_target),
    .opnd_ready(opnd_ready), .ex_alu_busy(ex_alu_busy), .cmp_grant(cmp_grant_3), .cmp_fun(cmp_fun_3),
    .cmp_result(cmp_result), .stall_id(stall_id_3), .pc_redirect(pc_redirect_3), .pc_target(pc_target_3),
    .flush_if(flush_if_3), .br_done(br_done_3)
`ifdef BR_STATS_EN
    , .stat_branches(stat_branches_3), .stat_taken(stat_taken_3), .stat_alu_conflicts(stat_alu_conflicts_3)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rise
  task automatic applyStimulus(input logic v, input logic [2:0] t, input logic [31:0] tgt,
                               input logic opnd, input logic busy, input logic res);
    @(negedge clk);
    br_valid    = v;
    br_type     = t;
    br_target   = tgt;
    opnd_ready  = opnd;
    ex_alu_busy = busy;
    cmp_result  = res;
    #1;
  endtask

  initial begin
    #2;
    checkOutput("rst_stall", {31'd0, stall_id}, 32'd0);
    checkOutput("rst_grant", {31'd0, cmp_grant}, 32'd0);
    checkOutput("rst_redirect", {31'd0, pc_redirect}, 32'd0);
    checkOutput("rst_flush", {31'd0, flush_if}, 32'd0);
    checkOutput("rst_done", {31'd0, br_done}, 32'd0);
    checkOutput("rst_target", pc_target, 32'd0);
    #10 reset = 1'b0;

    $display("[TB] BEQ taken, operands ready");
    applyStimulus(1'b1, BR_BEQ, 32'h0040_0100, 1'b1, 1'b0, 1'b1);
    checkOutput("t1_c0_stall", {31'd0, stall_id}, 32'd1);
    checkOutput("t1_c0_grant", {31'd0, cmp_grant}, 32'd0);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("t1_c1_grant", {31'd0, cmp_grant}, 32'd1);
    checkOutput("t1_c1_fun", {29'd0, cmp_fun}, 32'd1);
    checkOutput("t1_c1_stall", {31'd0, stall_id}, 32'd1);
    checkOutput("t1_c1_done", {31'd0, br_done}, 32'd0);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_c2_redirect", {31'd0, pc_redirect}, 32'd1);
    checkOutput("t1_c2_target", pc_target, 32'h0040_0100);
    checkOutput("t1_c2_flush", {31'd0, flush_if}, 32'd1);
    checkOutput("t1_c2_done", {31'd0, br_done}, 32'd1);
    checkOutput("t1_c2_stall", {31'd0, stall_id}, 32'd0);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_c3_redirect", {31'd0, pc_redirect}, 32'd0);
    checkOutput("t1_c3_flush", {31'd0, flush_if}, 32'd0);
    checkOutput("t1_c3_target", pc_target, 32'h0040_0100);

    $display("[TB] BNE taken after operand wait");
    applyStimulus(1'b1, BR_BNE, 32'h0040_0200, 1'b0, 1'b0, 1'b1);
    checkOutput("t2_c0_stall", {31'd0, stall_id}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 3'd0, 32'd0, (i == 2), 1'b0, 1'b1);
      checkOutput("t2_wait_stall", {31'd0, stall_id}, 32'd1);
      checkOutput("t2_wait_grant", {31'd0, cmp_grant}, 32'd0);
    end
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("t2_cmp_grant", {31'd0, cmp_grant}, 32'd1);
    checkOutput("t2_cmp_fun", {29'd0, cmp_fun}, 32'd0);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_redirect", {31'd0, pc_redirect}, 32'd1);
    checkOutput("t2_target", pc_target, 32'h0040_0200);

    $display("[TB] BGEZ with negative operand, new branch offered in done cycle");
    applyStimulus(1'b1, BR_BGEZ, 32'h0040_0300, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, BR_BEQ, 32'h0040_0400, 1'b1, 1'b0, 1'b1);
    checkOutput("t3_fun", {29'd0, cmp_fun}, 32'h5);
    checkOutput("t3_grant", {31'd0, cmp_grant}, 32'd1);
    checkOutput("t3_done", {31'd0, br_done}, 32'd1);
    checkOutput("t3_no_redirect_cmp", {31'd0, pc_redirect}, 32'd0);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("t3_not_accepted", {31'd0, cmp_grant}, 32'd0);
    checkOutput("t3_no_redirect", {31'd0, pc_redirect}, 32'd0);
    checkOutput("t3_target_kept", pc_target, 32'h0040_0300);

    $display("[TB] illegal type 6");
    applyStimulus(1'b1, 3'd6, 32'h0040_0500, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("ill_fun", {29'd0, cmp_fun}, 32'd0);
    checkOutput("ill_done", {31'd0, br_done}, 32'd1);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("ill_redirect", {31'd0, pc_redirect}, 32'd0);
    checkOutput("ill_flush", {31'd0, flush_if}, 32'd0);

    $display("[TB] BLTZ with ALU conflicts");
    applyStimulus(1'b1, BR_BLTZ, 32'h0040_0600, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("t4_busy1_grant", {31'd0, cmp_grant}, 32'd0);
    checkOutput("t4_busy1_fun", {29'd0, cmp_fun}, 32'h5);
    checkOutput("t4_busy1_stall", {31'd0, stall_id}, 32'd1);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("t4_busy2_grant", {31'd0, cmp_grant}, 32'd0);
    checkOutput("t4_busy2_done", {31'd0, br_done}, 32'd0);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("t4_grant", {31'd0, cmp_grant}, 32'd1);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_redirect", {31'd0, pc_redirect}, 32'd1);
    checkOutput("t4_target", pc_target, 32'h0040_0600);
`ifdef BR_STATS_EN
    checkOutput("t4_conflicts", {16'd0, stat_alu_conflicts}, 32'd2);
`endif
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef BR_STATS_EN
    checkOutput("stat_branches", stat_branches, 32'd5);
    checkOutput("stat_taken", stat_taken, 32'd3);
`endif

    $display("[TB] BGTZ taken with three flush cycles");
    sel3 = 1'b1;
    applyStimulus(1'b1, BR_BGTZ, 32'h0040_0700, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("t5_grant", {31'd0, cmp_grant_3}, 32'd1);
    checkOutput("t5_fun", {29'd0, cmp_fun_3}, 32'h7);
    applyStimulus(1'b1, BR_BEQ, 32'h0040_0800, 1'b1, 1'b0, 1'b1);
    checkOutput("t5_f1_flush", {31'd0, flush_if_3}, 32'd1);
    checkOutput("t5_f1_redirect", {31'd0, pc_redirect_3}, 32'd1);
    checkOutput("t5_f1_done", {31'd0, br_done_3}, 32'd0);
    checkOutput("t5_f1_target", pc_target_3, 32'h0040_0700);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_f2_flush", {31'd0, flush_if_3}, 32'd1);
    checkOutput("t5_f2_redirect", {31'd0, pc_redirect_3}, 32'd0);
    checkOutput("t5_f2_done", {31'd0, br_done_3}, 32'd0);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_f3_flush", {31'd0, flush_if_3}, 32'd1);
    checkOutput("t5_f3_done", {31'd0, br_done_3}, 32'd1);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_after_flush", {31'd0, flush_if_3}, 32'd0);
    checkOutput("t5_after_grant", {31'd0, cmp_grant_3}, 32'd0);
    checkOutput("t5_after_target", pc_target_3, 32'h0040_0700);
    sel3 = 1'b0;

    $display("[TB] asynchronous reset during operand wait");
    applyStimulus(1'b1, BR_BEQ, 32'h0040_0900, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_wait_stall", {31'd0, stall_id}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_rst_stall", {31'd0, stall_id}, 32'd0);
    checkOutput("t6_rst_grant", {31'd0, cmp_grant}, 32'd0);
    checkOutput("t6_rst_redirect", {31'd0, pc_redirect}, 32'd0);
    checkOutput("t6_rst_target", pc_target, 32'd0);
`ifdef BR_STATS_EN
    checkOutput("t6_rst_branches", stat_branches, 32'd0);
`endif
    #2 reset = 1'b0;
    applyStimulus(1'b1, BR_BEQ, 32'h0040_0A00, 1'b1, 1'b0, 1'b1);
    checkOutput("t6_new_stall", {31'd0, stall_id}, 32'd1);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("t6_new_grant", {31'd0, cmp_grant}, 32'd1);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_new_redirect", {31'd0, pc_redirect}, 32'd1);
    checkOutput("t6_new_target", pc_target, 32'h0040_0A00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
